// File: rtl/fifo_flops_flags.sv
// -----------------------------------------------------------------------------
// fifo_flops_flags
//   Flop-based synchronous FIFO with first-word fall-through output,
//   occupancy count, almost-full/almost-empty thresholds, sticky
//   overflow/underflow flags and a selectable full policy.
//
// Parameters
//   DEPTH    : number of entries (>= 2, any value, not only powers of two)
//   BITS     : data word width
//   AF_LVL   : almost_full when count >= AF_LVL (1..DEPTH)
//   AE_LVL   : almost_empty when count <= AE_LVL (0..DEPTH-1, < AF_LVL)
//   OVF_MODE : 0 = drop the incoming word when full, 1 = overwrite oldest
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-low reset
//   Din          : write data
//   push / pop   : write / read requests
//   clr_err      : clears the sticky error flags (a new error on the same
//                  edge takes priority)
//   Dout         : head-of-queue word, 0 while empty
//   pndng        : FIFO holds at least one word
//   full         : count == DEPTH
//   almost_full  : count >= AF_LVL
//   almost_empty : count <= AE_LVL
//   count        : current occupancy
//   overflow     : sticky, push attempted while full (without a pop)
//   underflow    : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module fifo_flops_flags #(
    parameter int DEPTH    = 16,
    parameter int BITS     = 16,
    parameter int AF_LVL   = 12,
    parameter int AE_LVL   = 4,
    parameter int OVF_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BITS-1:0]              Din,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [BITS-1:0]              Dout,
    output logic                         pndng,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Elaboration-time parameter sanity checks.
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fifo_flops_flags: DEPTH must be >= 2");
        end
        if (BITS < 1) begin : g_bad_bits
            $error("fifo_flops_flags: BITS must be >= 1");
        end
        if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
            $error("fifo_flops_flags: AF_LVL must be in 1..DEPTH");
        end
        if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
            $error("fifo_flops_flags: AE_LVL must be in 0..DEPTH-1");
        end
        if (AE_LVL >= AF_LVL) begin : g_bad_order
            $error("fifo_flops_flags: AE_LVL must be below AF_LVL");
        end
        if (OVF_MODE != 0 && OVF_MODE != 1) begin : g_bad_mode
            $error("fifo_flops_flags: OVF_MODE must be 0 or 1");
        end
    endgenerate

    // Storage is intentionally not reset; only pointers and count are.
    logic [BITS-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic is_full;
    logic is_empty;
    logic wr_en;
    logic rd_adv;
    logic ovf_event;
    logic unf_event;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign is_full  = (count_reg == CW'(DEPTH));
    assign is_empty = (count_reg == '0);

    // A write happens unless the FIFO is full with no pop in drop mode.
    // When empty, a simultaneous pop is ignored so the push still lands.
    assign wr_en = push && (!is_full || pop || (OVF_MODE != 0));

    // The read pointer moves on a real pop, or when an overwrite evicts
    // the oldest word.
    assign rd_adv = (pop && !is_empty) ||
                    (push && !pop && is_full && (OVF_MODE != 0));

    assign ovf_event = push && !pop && is_full;
    assign unf_event = pop && is_empty;

    always_comb begin
        wr_ptr_next    = wr_en  ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next    = rd_adv ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next     = count_reg;
        unique case ({wr_en, rd_adv})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        // Set has priority over clear.
        overflow_next  = ovf_event ? 1'b1 : (clr_err ? 1'b0 : overflow_reg);
        underflow_next = unf_event ? 1'b1 : (clr_err ? 1'b0 : underflow_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= Din;
        end
    end

    // Flags decode the registered count only.
    assign count        = count_reg;
    assign pndng        = !is_empty;
    assign full         = is_full;
    assign almost_full  = (count_reg >= CW'(AF_LVL));
    assign almost_empty = (count_reg <= CW'(AE_LVL));
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign Dout         = is_empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_fifo_flops_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_flops_flags
//   Three FIFO instances share one input stream:
//     dut0 : DEPTH=16, drop mode      (AF=12, AE=4)
//     dut1 : DEPTH=16, overwrite mode (AF=12, AE=4)
//     dut2 : DEPTH=12, overwrite mode (AF=9,  AE=3)
//   Every cycle all three are compared with an ordered-list reference model.
//   A table of directed vectors with hand-derived expectations targets dut0,
//   followed by hand sequences (wrap, async reset) and random traffic.
// -----------------------------------------------------------------------------
module tb_fifo_flops_flags;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        push;
    logic        pop;
    logic        clr_err;

    logic [15:0] dout_w  [3];
    logic [4:0]  count_w [3];
    logic        pndng_w [3];
    logic        full_w  [3];
    logic        af_w    [3];
    logic        ae_w    [3];
    logic        ovf_w   [3];
    logic        unf_w   [3];
    logic [3:0]  c2_count;

    assign count_w[2] = {1'b0, c2_count};

    fifo_flops_flags #(.DEPTH(16), .BITS(16), .AF_LVL(12), .AE_LVL(4), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop), .clr_err(clr_err),
        .Dout(dout_w[0]), .pndng(pndng_w[0]), .full(full_w[0]),
        .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(count_w[0]),
        .overflow(ovf_w[0]), .underflow(unf_w[0])
    );

    fifo_flops_flags #(.DEPTH(16), .BITS(16), .AF_LVL(12), .AE_LVL(4), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop), .clr_err(clr_err),
        .Dout(dout_w[1]), .pndng(pndng_w[1]), .full(full_w[1]),
        .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(count_w[1]),
        .overflow(ovf_w[1]), .underflow(unf_w[1])
    );

    fifo_flops_flags #(.DEPTH(12), .BITS(16), .AF_LVL(9), .AE_LVL(3), .OVF_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop), .clr_err(clr_err),
        .Dout(dout_w[2]), .pndng(pndng_w[2]), .full(full_w[2]),
        .almost_full(af_w[2]), .almost_empty(ae_w[2]), .count(c2_count),
        .overflow(ovf_w[2]), .underflow(unf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model: ordered list per instance -------------
    logic [15:0] mdata [3][16];
    int          mcnt  [3];
    bit          movf  [3];
    bit          munf  [3];

    function automatic int cfg_depth(input int k);
        return (k == 2) ? 12 : 16;
    endfunction
    function automatic int cfg_af(input int k);
        return (k == 2) ? 9 : 12;
    endfunction
    function automatic int cfg_ae(input int k);
        return (k == 2) ? 3 : 4;
    endfunction
    function automatic bit cfg_overwrite(input int k);
        return (k != 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            movf[k] = 1'b0;
            munf[k] = 1'b0;
        end
    endtask

    task automatic model_drop_head(input int k);
        for (int j = 0; j < 15; j++) mdata[k][j] = mdata[k][j+1];
        mcnt[k] = mcnt[k] - 1;
    endtask

    task automatic model_append(input int k, input logic [15:0] d);
        mdata[k][mcnt[k]] = d;
        mcnt[k] = mcnt[k] + 1;
    endtask

    task automatic model_step(input bit p, input bit po, input logic [15:0] d, input bit c);
        for (int k = 0; k < 3; k++) begin
            bit was_full;
            bit was_empty;
            was_full  = (mcnt[k] == cfg_depth(k));
            was_empty = (mcnt[k] == 0);
            if (po && !was_empty) model_drop_head(k);
            if (p) begin
                if (mcnt[k] < cfg_depth(k)) begin
                    model_append(k, d);
                end else if (cfg_overwrite(k)) begin
                    model_drop_head(k);
                    model_append(k, d);
                end
            end
            movf[k] = (p && !po && was_full) ? 1'b1 : (c ? 1'b0 : movf[k]);
            munf[k] = (po && was_empty)      ? 1'b1 : (c ? 1'b0 : munf[k]);
        end
    endtask

    // ---------------- comparison helpers -------------------------------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("count",        k, 32'(count_w[k]), 32'(mcnt[k]));
            chk("pndng",        k, 32'(pndng_w[k]), 32'(mcnt[k] != 0));
            chk("full",         k, 32'(full_w[k]),  32'(mcnt[k] == cfg_depth(k)));
            chk("almost_full",  k, 32'(af_w[k]),    32'(mcnt[k] >= cfg_af(k)));
            chk("almost_empty", k, 32'(ae_w[k]),    32'(mcnt[k] <= cfg_ae(k)));
            chk("dout",         k, 32'(dout_w[k]),  32'((mcnt[k] != 0) ? mdata[k][0] : 16'h0000));
            chk("overflow",     k, 32'(ovf_w[k]),   32'(movf[k]));
            chk("underflow",    k, 32'(unf_w[k]),   32'(munf[k]));
        end
    endtask

    // Called at a falling edge: drive, let the rising edge happen, then check.
    task automatic cycle(input bit p, input bit po, input logic [15:0] d, input bit c);
        push    = p;
        pop     = po;
        din     = d;
        clr_err = c;
        @(posedge clk);
        model_step(p, po, d, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        rst = 1'b0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
    endtask

    // ---------------- directed vector table (dut0) ---------------------------
    typedef struct {
        bit          push;
        bit          pop;
        bit          clr;
        logic [15:0] din;
        int          cnt;
        bit          full;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          unf;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add_vec(input bit p, input bit po, input bit c, input logic [15:0] d,
                           input int cnt, input bit fl, input bit af, input bit ae,
                           input bit ovf, input bit unf, input logic [15:0] dout);
        vecs[nvec] = '{push: p, pop: po, clr: c, din: d, cnt: cnt, full: fl,
                       af: af, ae: ae, ovf: ovf, unf: unf, dout: dout};
        nvec++;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;

        // Fill with 0..15: Dout stays at the first word, 0.
        for (int i = 0; i < 16; i++)
            add_vec(1, 0, 0, 16'(i), i + 1, (i == 15), (i + 1 >= 12), (i + 1 <= 4), 0, 0, 16'h0000);
        // Push while full in drop mode: word discarded, overflow set.
        add_vec(1, 0, 0, 16'hAAAA, 16, 1, 1, 0, 1, 0, 16'h0000);
        // Clear the flag.
        add_vec(0, 0, 1, 16'h0000, 16, 1, 1, 0, 0, 0, 16'h0000);
        // Drain: after popping word j the head is j+1.
        for (int j = 0; j < 16; j++)
            add_vec(0, 1, 0, 16'h0000, 15 - j, 0, (15 - j >= 12), (15 - j <= 4), 0, 0,
                    (j == 15) ? 16'h0000 : 16'(j + 1));
        // Pop on empty three times.
        for (int j = 0; j < 3; j++)
            add_vec(0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h0000);
        // Push+pop on empty: push lands, pop ignored, underflow stays set.
        add_vec(1, 1, 0, 16'h0055, 1, 0, 0, 1, 0, 1, 16'h0055);
        // Clear together with a legal pop.
        add_vec(0, 1, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000);
        // Clear together with a new underflow: set wins.
        add_vec(0, 1, 1, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h0000);
        // Plain clear.
        add_vec(0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000);

        do_reset();

        for (int i = 0; i < nvec; i++) begin
            cycle(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
            $display("vec %0d push=%0b pop=%0b clr=%0b din=%04h -> count=%0d dout=%04h ovf=%0b unf=%0b",
                     i, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din,
                     count_w[0], dout_w[0], ovf_w[0], unf_w[0]);
            chk("vec_count",  0, 32'(count_w[0]), 32'(vecs[i].cnt));
            chk("vec_pndng",  0, 32'(pndng_w[0]), 32'(vecs[i].cnt != 0));
            chk("vec_full",   0, 32'(full_w[0]),  32'(vecs[i].full));
            chk("vec_af",     0, 32'(af_w[0]),    32'(vecs[i].af));
            chk("vec_ae",     0, 32'(ae_w[0]),    32'(vecs[i].ae));
            chk("vec_ovf",    0, 32'(ovf_w[0]),   32'(vecs[i].ovf));
            chk("vec_unf",    0, 32'(unf_w[0]),   32'(vecs[i].unf));
            chk("vec_dout",   0, 32'(dout_w[0]),  32'(vecs[i].dout));
            // Overwrite instance after pushing 0xAAAA onto 0..15: oldest evicted.
            if (i == 16) begin
                chk("ovw_count", 1, 32'(count_w[1]), 32'd16);
                chk("ovw_dout",  1, 32'(dout_w[1]),  32'd1);
                chk("ovw_flag",  1, 32'(ovf_w[1]),   32'd1);
            end
        end

        // ---------------- continuous push+pop across pointer wrap -------------
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 16'(i), 0);
        for (int k = 0; k < 40; k++) begin
            cycle(1, 1, 16'(8 + k), 0);
            chk("wrap_count", 0, 32'(count_w[0]), 32'd8);
            chk("wrap_dout",  0, 32'(dout_w[0]),  32'(k + 1));
            chk("wrap_count", 2, 32'(count_w[2]), 32'd8);
            chk("wrap_dout",  2, 32'(dout_w[2]),  32'(k + 1));
        end
        $display("wrap sequence done: 40 push+pop cycles");

        // ---------------- asynchronous reset mid-operation --------------------
        do_reset();
        cycle(0, 1, 16'h0000, 0);             // underflow set
        for (int i = 0; i < 9; i++) cycle(1, 0, 16'(16'h0300 + i), 0);
        chk("pre_rst_count", 0, 32'(count_w[0]), 32'd9);
        #2;
        rst = 1'b0;
        model_reset();
        #1;                                   // still before the next rising edge
        chk("async_count", 0, 32'(count_w[0]), 32'd0);
        chk("async_pndng", 0, 32'(pndng_w[0]), 32'd0);
        chk("async_full",  1, 32'(full_w[1]),  32'd0);
        chk("async_unf",   0, 32'(unf_w[0]),   32'd0);
        chk("async_dout",  0, 32'(dout_w[0]),  32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 16'h1234, 0);
        chk("post_rst_count", 0, 32'(count_w[0]), 32'd1);
        chk("post_rst_dout",  0, 32'(dout_w[0]),  32'h1234);
        $display("async reset sequence done");

        // ---------------- randomized traffic vs. model ------------------------
        for (int n = 0; n < 3000; n++) begin
            int ph;
            int pp;
            ph = (n / 150) % 3;
            pp = (ph == 0) ? 80 : ((ph == 1) ? 50 : 20);
            cycle($urandom_range(99, 0) < pp,
                  $urandom_range(99, 0) < (100 - pp),
                  16'($urandom),
                  $urandom_range(99, 0) < 5);
        end
        $display("random traffic done: 3000 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
